// File: rtl/serial_frame_tx.sv
// Serial byte transmitter: idle-high, start bit, LSB-first data, stop bit(s), with a one-byte
// holding register. Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module serial_frame_tx #(
    parameter int unsigned TICKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] dataIn,
    output logic       serialOut,
    output logic       busy,
    output logic       empty,
    output logic       doneStrobe
);

    localparam int unsigned TW = $clog2(TICKS_PER_BIT);
    localparam int unsigned IW = 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef SERIAL_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 empty_q, empty_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 take;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        empty_d = empty_q;
        done_d  = 1'b0;
        take    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_end = (tick_q == TW'(TICKS_PER_BIT - 1));

        if (state_q != StIdle) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!empty_q) take = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    idx_d   = '0;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = StIdle;
                        // A queued byte starts its frame with no idle gap.
                        if (!empty_q) take = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            state_d = StStart;
            shift_d = hold_q;
            empty_d = 1'b1;
            tick_d  = '0;
            idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = ^hold_q;
`endif
        end

        // take implies empty_q == 0, so a same-edge load is dropped here.
        if (load && empty_q) begin
            hold_d  = dataIn[DATA_BITS-1:0];
            empty_d = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            empty_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            empty_q <= empty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        serialOut = 1'b1;
        unique case (state_q)
            StStart:  serialOut = 1'b0;
            StData:   serialOut = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
            StParity: serialOut = parity_q;
`endif
            default:  serialOut = 1'b1;
        endcase
    end

    assign busy       = busy_q;
    assign empty      = empty_q;
    assign doneStrobe = done_q;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmit end of the board's 16x-oversampled serial byte link. Frames parallel bytes from the HPS/Qsys side as idle-high, start-bit, LSB-first data, stop-bit serial.
- Bit timing matches the receive chain (startBitDetect / fourBitCounter / shiftIn), which samples at tick 7 of each 16-tick bit.
- A one-byte holding register lets the producer queue the next byte while the current frame is shifting, so back-to-back frames have no idle gap.

Parameters:
- TICKS_PER_BIT, 16, clock cycles per serial bit; must be >=2.
- DATA_BITS, 8, data bits per frame; 1..8.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clock  in  1  system clock (divided clock, same as receive chain)
- reset  in  1  synchronous, active-high reset
- load  in  1  producer write strobe; accepted only when empty=1
- dataIn  in  8  byte to send; bits above DATA_BITS ignored
- serialOut  out  1  serial line; idle high
- busy  out  1  high while a frame is on the line (START through last STOP tick)
- empty  out  1  holding register free; producer may assert load
- doneStrobe  out  1  one-cycle pulse when a frame's final stop tick completes

Behaviour:
- Reset (synchronous): serialOut=1, busy=0, empty=1, doneStrobe=0, FSM=IDLE, counters=0, holding register cleared. Applies mid-frame: line is high after the reset edge, frame aborted, queued byte discarded.
- Holding register:
  - load=1 with empty=1 at edge k: capture dataIn; empty=0 after k.
  - load=1 with empty=0: ignored; no state change, byte dropped.
- FSM states: IDLE, START, DATA, STOP[, PARITY].
  - IDLE: serialOut=1, busy=0. If the holding register is full at an edge: go to START, shift register <= hold, empty=1, tick=0.
  - START: serialOut=0 for TICKS_PER_BIT cycles.
  - DATA: serialOut=shift[0]; shift right at each bit end; bitIdx 0..DATA_BITS-1.
  - STOP: serialOut=1 for STOP_BITS*TICKS_PER_BIT cycles.
- Latency: load at edge k with FSM idle -> serialOut low after edge k+1. Data bit i is driven from edge k+1+TICKS_PER_BIT*(1+i).
- Tick counter counts 0..TICKS_PER_BIT-1 and wraps. A bit boundary is the edge where tick==TICKS_PER_BIT-1.
- End of the final stop tick:
  - doneStrobe=1 for exactly the following cycle.
  - If hold is full, enter START directly (no idle cycle) and reload from hold.
  - Otherwise go to IDLE and busy falls.
- Simultaneous load and hold->shift transfer at the same edge: empty was 0 going into that edge, so the load is ignored. The producer retries next cycle.
- busy is registered and is 1 from START entry through the last STOP tick.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the DATA_BITS data bits) for TICKS_PER_BIT cycles. Frame length becomes (2+DATA_BITS+STOP_BITS)*TICKS_PER_BIT.
- Undefined: no PARITY state, no parity logic. Frame length is (1+DATA_BITS+STOP_BITS)*TICKS_PER_BIT.

Test Plan:
- Reset check: hold reset 3 cycles, release -> serialOut=1, busy=0, empty=1, doneStrobe=0. No line activity for 200 cycles without load.
- Single byte: load 0xA5 at edge k -> serialOut=0 over cycles k+1..k+16. Then bits 1,0,1,0,0,1,0,1 (LSB first), 16 cycles each. Then high for 16 cycles. doneStrobe pulses once at k+161. busy falls at that same point.
- Back-to-back: load 0x00, then load 0xFF once empty=1 -> second start bit begins the cycle after the first stop bit ends. Zero idle cycles. Two doneStrobe pulses 160 cycles apart.
- Overrun: load 0x11, then 0x22 (accepted into hold), then 0x33 while empty=0 -> only 0x11 and 0x22 are transmitted; 0x33 never appears.
- Reset mid-frame: reset during data bit 3 of 0xC3 -> serialOut=1, busy=0, empty=1 the next cycle. A subsequent load of 0x5A transmits a clean frame.
- Loopback: serialOut into the receive chain, sending 0x00, 0x55, 0xAA, 0xFF -> receive parallel byte equals each sent byte. With SERIAL_TX_PARITY_EN, the parity bit for 0x07 is 1.
